calendar_date_counter: RTL and testbench
========================================

# calendar_date_counter

Registered day/month/year calendar counter for the millennium clock. It advances one day per `day_tick` pulse from the time-of-day chain and handles month lengths and the Gregorian or Julian leap rule. It supports parametrised year width and range, validated loads, and a sequential leap-year calculator. It replaces the standalone combinational leap-year check; the calendar display path and the date-setting logic connect here.

## Interface
- `YEAR_W`, 12: year register width.
- `YEAR_MIN`, 0: first year after wrap.
- `YEAR_MAX`, 2**YEAR_W-1: last year before wrap.
- `YEAR_RST`, 2000: year after reset.
- `GREGORIAN`, 1: 1 selects the Gregorian leap rule; 0 selects Julian (divisible by 4).
- `WEEKDAY_RST`, 5: weekday after reset, 0=Mon…6=Sun; used only with the macro.
- `clk`  in  1  Sole clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `day_tick`  in  1  One-cycle pulse; advance one day.
- `load`  in  1  One-cycle pulse; load the date below.
- `load_day`  in  5  Day, 1..31.
- `load_month`  in  4  Month, 1..12.
- `load_year`  in  YEAR_W  Year.
- `clr_ovf`  in  1  Clears `tick_ovf`.
- `day`  out  5  Current day.
- `month`  out  4  Current month.
- `year`  out  YEAR_W  Current year.
- `leap`  out  1  Current year is a leap year; valid while `busy`=0.
- `busy`  out  1  Leap calculation in progress.
- `load_err`  out  1  One-cycle pulse on a rejected or clamped load.
- `year_wrap`  out  1  One-cycle pulse when YEAR_MAX rolls to YEAR_MIN.
- `tick_ovf`  out  1  Sticky flag: a tick was dropped.

## Operation
- Reset values:
  - day=1, month=1, year=YEAR_RST.
  - leap = elaboration-time leap(YEAR_RST).
  - busy=0, load_err=0, year_wrap=0, tick_ovf=0.
  - Pending tick cleared.
- Reset mid-calculation aborts the calculation; no partial result reaches `leap`.
- Applied tick, day < month length: day+1.
- Applied tick at month end, month < 12: day=1, month+1.
- Applied tick on Dec 31: 01-01 of year+1. If year==YEAR_MAX, year becomes YEAR_MIN and `year_wrap` pulses.
- Month length: 31/30 per calendar; Feb is 28, or 29 when `leap`=1.
- Any year change (rollover or accepted load) starts the leap calculator and raises `busy`.
- Leap calculator, Gregorian: r = year mod 400 by restoring shift-subtract, one bit per cycle. leap = (r[1:0]==0) && r∉{100,200,300}.
- Leap calculator, Julian: leap = (year[1:0]==0).
- Tick while `busy`=0: applied.
- Tick while `busy`=1, nothing pending: held as pending; applied in the cycle `busy` falls.
- Tick while `busy`=1 with a tick already pending: dropped, `tick_ovf` set. `clr_ovf` clears it; a set in the same cycle wins.
- Load rules:
  - Load while `busy`=1: ignored, `load_err` pulses.
  - Load with month∉1..12 or day==0: rejected, date unchanged, `load_err` pulses.
  - Load otherwise: accepted.
- Load and tick in the same cycle (`busy`=0): load wins; the tick is discarded without setting `tick_ovf`.
- Clamping: after the calculation completes, a loaded day above the month length is clamped to the month length and `load_err` pulses in the completion cycle. Example: 30 Feb 2023 becomes 28 Feb.

## Timing
- All outputs are registered.
- Tick or load at edge n: new date visible after edge n.
- LEAP_LAT = YEAR_W+1 for Gregorian, 1 for Julian.
- After a year change at edge n, `busy`=1 for LEAP_LAT cycles. `leap` updates and `busy` falls after edge n+LEAP_LAT.
- A pending tick updates the date one cycle after `busy` falls.
- `load_err` and `year_wrap` pulse for exactly one cycle.

## Configuration
- `CAL_WEEKDAY_EN` defined:
  - Adds input `load_weekday`[2:0] and output `weekday`[2:0].
  - `weekday` resets to WEEKDAY_RST.
  - It increments mod 7 on every applied tick (6 wraps to 0).
  - It loads on an accepted load and is unchanged on a rejected load.
- `CAL_WEEKDAY_EN` undefined: both ports and the weekday logic are absent.

## Structure
- Package `cal_pkg` holds:
  - Month constants JAN..DEC.
  - `days_in_month(month, leap)` function.
  - Elaboration-time `is_leap(year, gregorian)` function.
  - LEAP_LAT derivation.
- Sub-module `leap_calc_seq`: start/busy/done handshake with a serial mod-400 divider and Julian bypass.

## Test plan
- Reset → date 2000-01-01, leap=1, busy=0, weekday=5 (with macro).
- Load 1900-02-28, wait `busy`=0 → leap=0. Tick → 1900-03-01.
- Load 2024-12-31, wait idle, tick → 2025-01-01 and busy for 13 cycles. Two ticks during busy → date reaches 2025-01-02 one cycle after busy falls and `tick_ovf`=1.
- Load 2023-02-30 → clamped to 2023-02-28 with a `load_err` pulse. Load month 13 → date unchanged with a `load_err` pulse.
- YEAR_W=12: load 4095-12-31, tick → 0000-01-01 with a `year_wrap` pulse. After the calculation, leap=1.
- GREGORIAN=0: load 1900 → busy for 1 cycle, leap=1.

Source files
------------

// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - calendar constants, month length and leap-year helpers
package cal_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] d;
        case (month)
            FEB:                d = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: d = 5'd30;
            default:            d = 5'd31;
        endcase
        return d;
    endfunction

    // Elaboration-time only; the hardware uses leap_calc_seq.
    function automatic bit is_leap(input int unsigned year, input bit gregorian);
        if (!gregorian)
            return (year % 4) == 0;
        return (((year % 4) == 0) && ((year % 100) != 0)) || ((year % 400) == 0);
    endfunction

    // Cycles from a year change until leap is valid: one per year bit of the
    // serial mod-400 divider plus the result cycle; Julian needs only the result cycle.
    function automatic int unsigned leap_lat(input int unsigned year_w, input bit gregorian);
        return gregorian ? year_w + 1 : 1;
    endfunction

endpackage

// File: rtl/leap_calc_seq.sv
// rtl/leap_calc_seq.sv - sequential leap-year calculator (serial mod-400, Julian bypass)
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse, latches start_year and raises busy
//   start_year  year to evaluate
//   busy        calculation in progress
//   done        final busy cycle; leap takes result at the closing edge
//   result      leap value being committed while done=1
//   leap        registered leap flag for the last completed year
module leap_calc_seq
    import cal_pkg::*;
#(
    parameter int YEAR_W    = 12,
    parameter bit GREGORIAN = 1'b1,
    parameter bit LEAP_RST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [YEAR_W-1:0] start_year,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic              leap
);

    localparam int unsigned LEAP_LAT = leap_lat(YEAR_W, GREGORIAN);
    localparam int          CNT_W    = $clog2(YEAR_W + 1);

    logic [YEAR_W-1:0] shreg;
    logic [8:0]        rem;
    logic [8:0]        rem_next;
    logic [9:0]        trial;
    logic [CNT_W-1:0]  cnt;

    always_comb begin
        // Restoring step: bring in the next year bit, subtract 400 if it fits.
        trial    = {rem, shreg[YEAR_W-1]};
        rem_next = (trial >= 10'd400) ? 9'(trial - 10'd400) : trial[8:0];
        if (GREGORIAN)
            result = (rem[1:0] == 2'b00) && (rem != 9'd100) && (rem != 9'd200) && (rem != 9'd300);
        else
            result = (shreg[1:0] == 2'b00);
        done = busy && (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            leap  <= LEAP_RST;
            cnt   <= '0;
            shreg <= '0;
            rem   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            shreg <= start_year;
            rem   <= '0;
            cnt   <= CNT_W'(LEAP_LAT - 1);
        end else if (busy) begin
            if (cnt != '0) begin
                rem   <= rem_next;
                shreg <= {shreg[YEAR_W-2:0], 1'b0};
                cnt   <= cnt - CNT_W'(1);
            end else begin
                leap <= result;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calendar_date_counter.sv
// rtl/calendar_date_counter.sv - day/month/year calendar counter with validated loads
// Optional feature macro: CAL_WEEKDAY_EN (adds load_weekday / weekday).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   day_tick                           advance one day
//   load, load_day/month/year          load a date
//   clr_ovf                            clear tick_ovf
//   day, month, year                   current date
//   leap, busy                         leap flag (valid when busy=0), leap calculation running
//   load_err, year_wrap                one-cycle pulses
//   tick_ovf                           sticky dropped-tick flag
//   load_weekday, weekday              weekday load / current weekday (CAL_WEEKDAY_EN)
module calendar_date_counter
    import cal_pkg::*;
#(
    parameter int          YEAR_W    = 12,
    parameter int unsigned YEAR_MIN  = 0,
    parameter int unsigned YEAR_MAX  = 2**YEAR_W - 1,
    parameter int unsigned YEAR_RST  = 2000,
    parameter bit          GREGORIAN = 1'b1
`ifdef CAL_WEEKDAY_EN
    ,
    parameter int unsigned WEEKDAY_RST = 5
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic              clr_ovf,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic              busy,
    output logic              load_err,
    output logic              year_wrap,
    output logic              tick_ovf
`ifdef CAL_WEEKDAY_EN
    ,
    input  logic [2:0]        load_weekday,
    output logic [2:0]        weekday
`endif
);

    logic              calc_start;
    logic              calc_busy;
    logic              calc_done;
    logic              calc_result;
    logic [YEAR_W-1:0] calc_year;

    logic              pending;
    logic              clamp_pend;
    logic [4:0]        dim;
    logic [4:0]        dim_new;
    logic              load_ok;
    logic              accept;
    logic              apply;
    logic              drop;
    logic              clamp;
    logic              roll;
    logic [4:0]        day_next;
    logic [3:0]        month_next;
    logic [YEAR_W-1:0] year_next;
    logic              wrap_next;

    leap_calc_seq #(
        .YEAR_W    (YEAR_W),
        .GREGORIAN (GREGORIAN),
        .LEAP_RST  (is_leap(YEAR_RST, GREGORIAN))
    ) u_leap_calc (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (calc_start),
        .start_year (calc_year),
        .busy       (calc_busy),
        .done       (calc_done),
        .result     (calc_result),
        .leap       (leap)
    );

    assign busy = calc_busy;

    always_comb begin
        dim     = days_in_month(month, leap);
        dim_new = days_in_month(month, calc_result);
        load_ok = (load_month >= JAN) && (load_month <= DEC) && (load_day != 5'd0);
        accept  = load && !calc_busy && load_ok;
        // Any load while idle takes priority over a tick, accepted or not.
        apply   = !calc_busy && !load && (day_tick || pending);
        drop    = calc_busy && day_tick && pending;
        // Clamp against the freshly computed leap value, committed in the same edge.
        clamp   = calc_done && clamp_pend && (day > dim_new);

        day_next   = day;
        month_next = month;
        year_next  = year;
        wrap_next  = 1'b0;
        roll       = 1'b0;
        if (day < dim) begin
            day_next = day + 5'd1;
        end else if (month < DEC) begin
            day_next   = 5'd1;
            month_next = month + 4'd1;
        end else begin
            day_next   = 5'd1;
            month_next = JAN;
            roll       = 1'b1;
            if (year == YEAR_W'(YEAR_MAX)) begin
                year_next = YEAR_W'(YEAR_MIN);
                wrap_next = 1'b1;
            end else begin
                year_next = year + YEAR_W'(1);
            end
        end

        calc_start = accept || (apply && roll);
        calc_year  = accept ? load_year : year_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day        <= 5'd1;
            month      <= JAN;
            year       <= YEAR_W'(YEAR_RST);
            pending    <= 1'b0;
            clamp_pend <= 1'b0;
            load_err   <= 1'b0;
            year_wrap  <= 1'b0;
            tick_ovf   <= 1'b0;
        end else begin
            load_err  <= (load && !accept) || clamp;
            year_wrap <= apply && wrap_next;
            tick_ovf  <= drop || (tick_ovf && !clr_ovf);

            // At most one tick is held across a calculation. When a pending
            // tick and a fresh tick meet in an idle cycle, one is applied and
            // the other stays pending.
            if (calc_busy) begin
                if (day_tick)
                    pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end else begin
                pending <= pending && day_tick;
            end

            if (accept) begin
                day        <= load_day;
                month      <= load_month;
                year       <= load_year;
                clamp_pend <= 1'b1;
            end else if (apply) begin
                day   <= day_next;
                month <= month_next;
                year  <= year_next;
            end else if (calc_done) begin
                clamp_pend <= 1'b0;
                if (clamp)
                    day <= dim_new;
            end
        end
    end

`ifdef CAL_WEEKDAY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            weekday <= 3'(WEEKDAY_RST);
        else if (accept)
            weekday <= load_weekday;
        else if (apply)
            weekday <= (weekday >= 3'd6) ? 3'd0 : weekday + 3'd1;
    end
`endif

endmodule

// File: tb/tb_calendar_date_counter.sv
// tb/tb_calendar_date_counter.sv - directed scoreboard bench for calendar_date_counter
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        day_tick, load, clr_ovf;
    logic [4:0]  load_day;
    logic [3:0]  load_month;
    logic [11:0] load_year;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic        leap, busy, load_err, year_wrap, tick_ovf;

    logic        day_tick_b, load_b, clr_ovf_b;
    logic [4:0]  load_day_b;
    logic [3:0]  load_month_b;
    logic [11:0] load_year_b;
    logic [4:0]  day_b;
    logic [3:0]  month_b;
    logic [11:0] year_b;
    logic        leap_b, busy_b, load_err_b, year_wrap_b, tick_ovf_b;

`ifdef CAL_WEEKDAY_EN
    logic [2:0]  load_weekday = 3'd0;
    logic [2:0]  weekday;
    logic [2:0]  load_weekday_b = 3'd0;
    logic [2:0]  weekday_b;
`endif

    always #5 clk = ~clk;

    calendar_date_counter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_tick   (day_tick),
        .load       (load),
        .load_day   (load_day),
        .load_month (load_month),
        .load_year  (load_year),
        .clr_ovf    (clr_ovf),
        .day        (day),
        .month      (month),
        .year       (year),
        .leap       (leap),
        .busy       (busy),
        .load_err   (load_err),
        .year_wrap  (year_wrap),
        .tick_ovf   (tick_ovf)
`ifdef CAL_WEEKDAY_EN
        ,
        .load_weekday (load_weekday),
        .weekday      (weekday)
`endif
    );

    calendar_date_counter #(.GREGORIAN(1'b0)) dut_julian (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_tick   (day_tick_b),
        .load       (load_b),
        .load_day   (load_day_b),
        .load_month (load_month_b),
        .load_year  (load_year_b),
        .clr_ovf    (clr_ovf_b),
        .day        (day_b),
        .month      (month_b),
        .year       (year_b),
        .leap       (leap_b),
        .busy       (busy_b),
        .load_err   (load_err_b),
        .year_wrap  (year_wrap_b),
        .tick_ovf   (tick_ovf_b)
`ifdef CAL_WEEKDAY_EN
        ,
        .load_weekday (load_weekday_b),
        .weekday      (weekday_b)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] dt(input int y, input int m, input int d);
        return (32'(y) << 9) | (32'(m) << 5) | 32'(d);
    endfunction

    function automatic logic [31:0] date_a();
        return {11'd0, year, month, day};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] val);
        sb_entry_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_entry_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h, expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %0h, expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic do_load_a(input int y, input int m, input int d);
        load       = 1'b1;
        load_year  = 12'(y);
        load_month = 4'(m);
        load_day   = 5'(d);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_load_b(input int y, input int m, input int d);
        load_b       = 1'b1;
        load_year_b  = 12'(y);
        load_month_b = 4'(m);
        load_day_b   = 5'(d);
        @(negedge clk);
        load_b = 1'b0;
    endtask

    task automatic do_tick_a();
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
    endtask

    // Number of clock edges until busy is seen low, bounded.
    task automatic wait_idle(input bit sel, output int n);
        n = 0;
        while ((sel ? busy_b : busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        {day_tick, load, clr_ovf, load_day, load_month, load_year} = '0;
        {day_tick_b, load_b, clr_ovf_b, load_day_b, load_month_b, load_year_b} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        expect_val("rst_date", dt(2000, 1, 1));      chk(date_a());
        expect_val("rst_leap", 1);                   chk(32'(leap));
        expect_val("rst_busy", 0);                   chk(32'(busy));
        expect_val("rst_flags", 0);                  chk(32'({load_err, year_wrap, tick_ovf}));
        expect_val("rst_leap_julian", 1);            chk(32'(leap_b));
`ifdef CAL_WEEKDAY_EN
        expect_val("rst_weekday", 5);                chk(32'(weekday));
`endif

        // Century non-leap year, Feb 28 -> Mar 1
        do_load_a(1900, 2, 28);
        expect_val("ld1900_date", dt(1900, 2, 28));  chk(date_a());
        wait_idle(0, n);
        expect_val("ld1900_latency", 13);            chk(32'(n));
        expect_val("ld1900_leap", 0);                chk(32'(leap));
        do_tick_a();
        expect_val("tick_1900_feb28", dt(1900, 3, 1)); chk(date_a());

        // Year rollover, pending tick and dropped tick
        do_load_a(2024, 12, 31);
        wait_idle(0, n);
        expect_val("ld2024_leap", 1);                chk(32'(leap));
        do_tick_a();
        expect_val("roll_date", dt(2025, 1, 1));     chk(date_a());
        expect_val("roll_busy", 1);                  chk(32'(busy));
        do_tick_a();
        do_tick_a();
        expect_val("ovf_set", 1);                    chk(32'(tick_ovf));
        wait_idle(0, n);
        expect_val("roll_busy_len", 13);             chk(32'(n + 2));
        expect_val("roll_leap", 0);                  chk(32'(leap));
        expect_val("pending_not_yet", dt(2025, 1, 1)); chk(date_a());
        @(negedge clk);
        expect_val("pending_applied", dt(2025, 1, 2)); chk(date_a());
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        expect_val("ovf_cleared", 0);                chk(32'(tick_ovf));

        // Clamped load
        do_load_a(2023, 2, 30);
        expect_val("clamp_raw", dt(2023, 2, 30));    chk(date_a());
        expect_val("clamp_noerr_early", 0);          chk(32'(load_err));
        wait_idle(0, n);
        expect_val("clamp_date", dt(2023, 2, 28));   chk(date_a());
        expect_val("clamp_err", 1);                  chk(32'(load_err));
        @(negedge clk);
        expect_val("clamp_err_pulse", 0);            chk(32'(load_err));

        // Rejected loads
        do_load_a(1999, 13, 5);
        expect_val("bad_month_err", 1);              chk(32'(load_err));
        expect_val("bad_month_date", dt(2023, 2, 28)); chk(date_a());
        expect_val("bad_month_busy", 0);             chk(32'(busy));
        @(negedge clk);
        expect_val("bad_month_err_pulse", 0);        chk(32'(load_err));
        do_load_a(1999, 5, 0);
        expect_val("bad_day_err", 1);                chk(32'(load_err));
        expect_val("bad_day_date", dt(2023, 2, 28)); chk(date_a());

        // Load while busy is ignored
        do_load_a(2020, 6, 15);
        do_load_a(2021, 1, 1);
        expect_val("busy_load_err", 1);              chk(32'(load_err));
        expect_val("busy_load_date", dt(2020, 6, 15)); chk(date_a());
        wait_idle(0, n);
        expect_val("ld2020_leap", 1);                chk(32'(leap));

        // Year wrap at YEAR_MAX
        do_load_a(4095, 12, 31);
        wait_idle(0, n);
        expect_val("ld4095_leap", 0);                chk(32'(leap));
        do_tick_a();
        expect_val("wrap_date", dt(0, 1, 1));        chk(date_a());
        expect_val("wrap_pulse", 1);                 chk(32'(year_wrap));
        @(negedge clk);
        expect_val("wrap_pulse_end", 0);             chk(32'(year_wrap));
        wait_idle(0, n);
        expect_val("wrap_leap", 1);                  chk(32'(leap));

        // Load and tick together: load wins, no overflow, no pending tick
        day_tick = 1'b1;
        do_load_a(2010, 3, 10);
        day_tick = 1'b0;
        expect_val("ldtick_date", dt(2010, 3, 10));  chk(date_a());
        expect_val("ldtick_ovf", 0);                 chk(32'(tick_ovf));
        wait_idle(0, n);
        @(negedge clk);
        expect_val("ldtick_no_pending", dt(2010, 3, 10)); chk(date_a());

        // Reset mid-calculation
        do_load_a(2023, 5, 5);
        repeat (3) @(negedge clk);
        expect_val("midcalc_busy", 1);               chk(32'(busy));
        rst_n = 1'b0;
        #2;
        expect_val("midcalc_rst_busy", 0);           chk(32'(busy));
        expect_val("midcalc_rst_leap", 1);           chk(32'(leap));
        expect_val("midcalc_rst_date", dt(2000, 1, 1)); chk(date_a());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Julian instance
        do_load_b(1900, 1, 1);
        expect_val("julian_busy", 1);                chk(32'(busy_b));
        wait_idle(1, n);
        expect_val("julian_latency", 1);             chk(32'(n));
        expect_val("julian_1900_leap", 1);           chk(32'(leap_b));
        do_load_b(1901, 1, 1);
        wait_idle(1, n);
        expect_val("julian_1901_leap", 0);           chk(32'(leap_b));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
